// File: rtl/alu_pkg.sv
// Shared ALU encodings: op codes, RV32 major opcodes and forward selects.
// Imported by both the issue stage and the execute ALU so both ends agree.
package alu_pkg;

   localparam int unsigned ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_AND     = 4'b0000,
      OP_OR      = 4'b0001,
      OP_ADD     = 4'b0010,
      OP_SUB     = 4'b0011,
      OP_XOR     = 4'b0100,
      OP_SLL     = 4'b0101,
      OP_SRL     = 4'b0110,
      OP_EQ      = 4'b1000,
      OP_ILLEGAL = 4'b1111
   } alu_op_e;

   localparam logic [6:0] RV_OP_R      = 7'b0110011;
   localparam logic [6:0] RV_OP_IMM    = 7'b0010011;
   localparam logic [6:0] RV_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] RV_OP_STORE  = 7'b0100011;
   localparam logic [6:0] RV_OP_BRANCH = 7'b1100011;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_WB    = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of (opcode, funct3, funct7_b5) into ALU op and control.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   output alu_op_e    operation,
   output logic       use_imm,
   output logic       shift,
   output logic       reg_write_raw,
   output logic       is_branch,
   output logic       illegal
);

   // Op-code and control decode; illegal encodings suppress write and branch
   always_comb begin
      operation     = OP_ILLEGAL;
      use_imm       = 1'b0;
      reg_write_raw = 1'b0;
      is_branch     = 1'b0;
      case (opcode)
         RV_OP_R, RV_OP_IMM: begin
            use_imm       = (opcode == RV_OP_IMM);
            reg_write_raw = 1'b1;
            case (funct3)
               3'b000: begin
                  if ((opcode == RV_OP_R) && funct7_b5) operation = OP_SUB;
                  else                                  operation = OP_ADD;
               end
               3'b111: operation = OP_AND;
               3'b110: operation = OP_OR;
               3'b100: operation = OP_XOR;
               3'b001: operation = OP_SLL;
               3'b101: if (!funct7_b5) operation = OP_SRL;
               default: operation = OP_ILLEGAL;
            endcase
         end
         RV_OP_LOAD: begin
            operation     = OP_ADD;
            use_imm       = 1'b1;
            reg_write_raw = 1'b1;
         end
         RV_OP_STORE: begin
            operation = OP_ADD;
            use_imm   = 1'b1;
         end
         RV_OP_BRANCH: begin
            if (funct3 == 3'b000) begin
               operation = OP_EQ;
               is_branch = 1'b1;
            end
         end
         default: operation = OP_ILLEGAL;
      endcase
      shift   = (operation == OP_SLL) || (operation == OP_SRL);
      illegal = (operation == OP_ILLEGAL);
      if (illegal) begin
         reg_write_raw = 1'b0;
         is_branch     = 1'b0;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: operand forwarding muxes, shift-amount masking and the
// ID/EX pipeline register under a valid/ready handshake with stall and flush.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [6:0]               opcode,
   input  logic [2:0]               funct3,
   input  logic                     funct7_b5,
   input  logic [4:0]               rd_in,
   input  logic [DATA_WIDTH-1:0]    rs1_data,
   input  logic [DATA_WIDTH-1:0]    rs2_data,
   input  logic [DATA_WIDTH-1:0]    imm,
   input  logic [1:0]               fwd_a,
   input  logic [1:0]               fwd_b,
   input  logic [DATA_WIDTH-1:0]    exmem_result,
   input  logic [DATA_WIDTH-1:0]    wb_result,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic [4:0]               rd_out,
   output logic                     reg_write,
   output logic                     is_branch,
   output logic                     illegal
);

   alu_op_e               dec_op;
   logic                  dec_use_imm;
   logic                  dec_shift;
   logic                  dec_rw_raw;
   logic                  dec_branch;
   logic                  dec_illegal;
   logic [DATA_WIDTH-1:0] a_fwd;
   logic [DATA_WIDTH-1:0] b_fwd;
   logic [DATA_WIDTH-1:0] b_opnd;
   logic                  accept;

   alu_op_decode u_dec (
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7_b5     (funct7_b5),
      .operation     (dec_op),
      .use_imm       (dec_use_imm),
      .shift         (dec_shift),
      .reg_write_raw (dec_rw_raw),
      .is_branch     (dec_branch),
      .illegal       (dec_illegal)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Forwarding muxes; select 11 falls back to the register file
   always_comb begin
      case (fwd_a)
         FWD_WB:    a_fwd = wb_result;
         FWD_EXMEM: a_fwd = exmem_result;
         default:   a_fwd = rs1_data;
      endcase
      case (fwd_b)
         FWD_WB:    b_fwd = wb_result;
         FWD_EXMEM: b_fwd = exmem_result;
         default:   b_fwd = rs2_data;
      endcase
   end

   // Operand B: immediate select, then shift-amount masking to 5 bits
   always_comb begin
      b_opnd = dec_use_imm ? imm : b_fwd;
      if (dec_shift) b_opnd = {{(DATA_WIDTH-5){1'b0}}, b_opnd[4:0]};
   end

   // ID/EX register: flush beats load, load beats drain, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         SrcA      <= '0;
         SrcB      <= '0;
         Operation <= '0;
         rd_out    <= '0;
         reg_write <= 1'b0;
         is_branch <= 1'b0;
         illegal   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         reg_write <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         SrcA      <= a_fwd;
         SrcB      <= b_opnd;
         Operation <= OPCODE_LENGTH'(dec_op);
         rd_out    <= rd_in;
         reg_write <= dec_rw_raw && (rd_in != 5'd0);
         is_branch <= dec_branch;
         illegal   <= dec_illegal;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
